// File: rtl/crypto_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package : crypto_tx_pkg
// Shared block geometry, cipher FSM state type and block type.
// Rev     : 1.0
// ============================================================================
package crypto_tx_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_BUSY = 2'd1,
        C_HOLD = 2'd2
    } cipher_state_t;

    typedef logic [15:0][7:0] block_t;

endpackage
`default_nettype wire

// File: rtl/crypto_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : crypto_tx_scheduler_if
// Sample, cipher and tx handshake bundle. master = scheduler, slave = env.
// Rev       : 1.0
// ============================================================================
interface crypto_tx_scheduler_if #(
    parameter int DROP_CNT_W = 8
);
    logic                  enable_in;
    logic                  sample_valid_in;
    logic [7:0]            sample_in;
    logic                  cipher_start_out;
    logic [127:0]          cipher_block_out;
    logic                  cipher_valid_in;
    logic [127:0]          cipher_block_in;
    logic                  tx_valid_out;
    logic [7:0]            tx_byte_out;
    logic                  tx_busy_in;
    logic                  busy_out;
    logic [DROP_CNT_W-1:0] drop_count_out;
    logic                  timeout_err_out;

    modport master (
        input  enable_in, sample_valid_in, sample_in,
        input  cipher_valid_in, cipher_block_in, tx_busy_in,
        output cipher_start_out, cipher_block_out,
        output tx_valid_out, tx_byte_out,
        output busy_out, drop_count_out, timeout_err_out
    );

    modport slave (
        output enable_in, sample_valid_in, sample_in,
        output cipher_valid_in, cipher_block_in, tx_busy_in,
        input  cipher_start_out, cipher_block_out,
        input  tx_valid_out, tx_byte_out,
        input  busy_out, drop_count_out, timeout_err_out
    );
endinterface
`default_nettype wire

// File: rtl/block_drain.sv
`default_nettype none
// ============================================================================
// Module : block_drain
// Holds one encoded block and emits it a byte per pacing tick, stalling on tx busy.
// Rev    : 1.0
// ============================================================================
module block_drain
    import crypto_tx_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       load,
    input  block_t     load_block,
    input  logic       tick,
    input  logic       tx_busy,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       empty
);
    block_t     enc;
    logic [3:0] didx;
    logic       full;

    // load is only ever requested while empty, so it never races an emit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            enc      <= '0;
            didx     <= 4'd0;
            full     <= 1'b0;
            tx_valid <= 1'b0;
            tx_byte  <= 8'd0;
        end else begin
            tx_valid <= 1'b0;
            if (load) begin
                enc  <= load_block;
                didx <= 4'd0;
                full <= 1'b1;
            end else if (full && tick && !tx_busy) begin
                tx_valid <= 1'b1;
                tx_byte  <= enc[didx];
                didx     <= didx + 4'd1;
                if (didx == 4'd15) begin
                    full <= 1'b0;
                end
            end
        end
    end

    assign empty = ~full;

endmodule
`default_nettype wire

// File: rtl/crypto_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : crypto_tx_scheduler
// Audio samples -> 16-byte blocks -> cipher -> paced byte drain to tx.
// Option : CRYPTO_TX_BYPASS_EN skips the cipher (plaintext goes to the drain).
// Rev    : 1.0
// ============================================================================
module crypto_tx_scheduler #(
    parameter int BLOCK_BYTES    = crypto_tx_pkg::BLOCK_BYTES,
    parameter int CIPHER_TIMEOUT = 4096,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    crypto_tx_scheduler_if.master bus
);
    import crypto_tx_pkg::*;

    localparam int                 TIMER_W    = (CIPHER_TIMEOUT > 1) ? $clog2(CIPHER_TIMEOUT) : 1;
    localparam logic [3:0]         LAST_IDX   = 4'(BLOCK_BYTES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CIPHER_TIMEOUT - 1);

    cipher_state_t         state;
    block_t                fill;
    block_t                w_block;
    block_t                hold;
    block_t                blk_out;
    block_t                w_load_block;
    logic [3:0]            idx;
    logic [TIMER_W-1:0]    timer;
    logic [DROP_CNT_W-1:0] drops;
    logic                  start_r;
    logic                  err;
    logic                  w_complete;
    logic                  w_load;
    logic                  drain_empty;
    logic                  tx_valid;
    logic [7:0]            tx_byte;

    always_comb begin
        w_block      = fill;
        w_block[idx] = bus.sample_in;
        w_complete   = bus.sample_valid_in && bus.enable_in && (idx == LAST_IDX);
`ifdef CRYPTO_TX_BYPASS_EN
        w_load       = (state == C_HOLD) && drain_empty;
        w_load_block = hold;
`else
        // Direct load: the cipher result goes straight into an empty drain
        w_load       = drain_empty &&
                       (((state == C_BUSY) && bus.cipher_valid_in) || (state == C_HOLD));
        w_load_block = (state == C_BUSY) ? block_t'(bus.cipher_block_in) : hold;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fill  <= '0;
            idx   <= 4'd0;
            drops <= '0;
        end else if (!bus.enable_in) begin
            idx <= 4'd0;
        end else if (bus.sample_valid_in) begin
            fill[idx] <= bus.sample_in;
            idx       <= w_complete ? 4'd0 : idx + 4'd1;
            if (w_complete && (state != C_IDLE) && (drops != {DROP_CNT_W{1'b1}})) begin
                drops <= drops + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= C_IDLE;
            hold    <= '0;
            blk_out <= '0;
            timer   <= '0;
            start_r <= 1'b0;
            err     <= 1'b0;
        end else begin
            start_r <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (w_complete) begin
                        blk_out <= w_block;
`ifdef CRYPTO_TX_BYPASS_EN
                        hold  <= w_block;
                        state <= C_HOLD;
`else
                        start_r <= 1'b1;
                        timer   <= '0;
                        state   <= C_BUSY;
`endif
                    end
                end
                C_BUSY: begin
                    if (bus.cipher_valid_in) begin
                        hold  <= bus.cipher_block_in;
                        state <= drain_empty ? C_IDLE : C_HOLD;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        state <= C_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                C_HOLD: begin
                    if (drain_empty) begin
                        state <= C_IDLE;
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end

    block_drain u_drain (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load       (w_load),
        .load_block (w_load_block),
        .tick       (bus.sample_valid_in),
        .tx_busy    (bus.tx_busy_in),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .empty      (drain_empty)
    );

    assign bus.cipher_start_out = start_r;
    assign bus.cipher_block_out = blk_out;
    assign bus.tx_valid_out     = tx_valid;
    assign bus.tx_byte_out      = tx_byte;
    assign bus.busy_out         = (state != C_IDLE) || !drain_empty;
    assign bus.drop_count_out   = drops;
    assign bus.timeout_err_out  = err;

endmodule
`default_nettype wire

// File: tb/tb_crypto_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_crypto_tx_scheduler
// Randomized bench with a queue-based reference model and literal scenario checks.
// Rev    : 1.0
// ============================================================================
module tb_crypto_tx_scheduler;
    import crypto_tx_pkg::*;

    localparam int TMO = 100;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    crypto_tx_scheduler_if #(.DROP_CNT_W(8)) bus();

    crypto_tx_scheduler #(
        .BLOCK_BYTES    (16),
        .CIPHER_TIMEOUT (TMO),
        .DROP_CNT_W     (8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (byte queues, one step per clock) ----------
    logic [7:0]   fill_q[$];
    logic [7:0]   drain_q[$];
    bit           m_wait, m_hold;
    int           m_age;
    logic [127:0] m_held;
    logic         e_start, e_txv, e_err, e_busy;
    logic [7:0]   e_txb, e_drop;
    logic [127:0] e_blk;

    task automatic model_reset();
        fill_q.delete(); drain_q.delete();
        m_wait = 0; m_hold = 0; m_age = 0; m_held = '0;
        e_start = 0; e_txv = 0; e_err = 0; e_busy = 0;
        e_txb = 0; e_drop = 0; e_blk = '0;
    endtask

    task automatic model_load(input logic [127:0] b);
        for (int i = 0; i < 16; i++) drain_q.push_back(b[8*i +: 8]);
    endtask

    task automatic model_step();
        bit idle_pre, dempty_pre;
        logic [127:0] blk;
        idle_pre   = !m_wait && !m_hold;
        dempty_pre = (drain_q.size() == 0);
        e_start = 0;
        e_txv   = 0;
        if (!dempty_pre && bus.sample_valid_in && !bus.tx_busy_in) begin
            e_txv = 1;
            e_txb = drain_q.pop_front();
        end
        if (m_wait) begin
            if (bus.cipher_valid_in) begin
                m_wait = 0;
                if (dempty_pre) model_load(bus.cipher_block_in);
                else begin m_held = bus.cipher_block_in; m_hold = 1; end
            end else if (m_age == TMO - 1) begin
                e_err  = 1;
                m_wait = 0;
            end else begin
                m_age++;
            end
        end else if (m_hold && dempty_pre) begin
            model_load(m_held);
            m_hold = 0;
        end
        if (!bus.enable_in) begin
            fill_q.delete();
        end else if (bus.sample_valid_in) begin
            fill_q.push_back(bus.sample_in);
            if (fill_q.size() == 16) begin
                for (int i = 0; i < 16; i++) blk[8*i +: 8] = fill_q[i];
                if (idle_pre) begin
                    e_blk = blk; e_start = 1; m_wait = 1; m_age = 0;
                end else if (e_drop != 8'hFF) begin
                    e_drop++;
                end
                fill_q.delete();
            end
        end
        e_busy = m_wait || m_hold || (drain_q.size() != 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in);
            cyc++;
            if (!rst_n_in) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and monitor ------------------------------
    logic [7:0] tx_log[$];
    int  start_cnt = 0, start_cyc = 0, err_cyc = 0;
    bit  err_seen  = 0;

    initial forever begin
        @(negedge clk_in);
        if (rst_n_in) begin
            chk("start",    {127'd0, bus.cipher_start_out}, {127'd0, e_start});
            chk("blk_out",  bus.cipher_block_out,           e_blk);
            chk("tx_valid", {127'd0, bus.tx_valid_out},     {127'd0, e_txv});
            chk("tx_byte",  {120'd0, bus.tx_byte_out},      {120'd0, e_txb});
            chk("drop",     {120'd0, bus.drop_count_out},   {120'd0, e_drop});
            chk("err",      {127'd0, bus.timeout_err_out},  {127'd0, e_err});
            chk("busy",     {127'd0, bus.busy_out},         {127'd0, e_busy});
            if (bus.tx_valid_out) tx_log.push_back(bus.tx_byte_out);
            if (bus.cipher_start_out) begin start_cnt++; start_cyc = cyc; end
            if (bus.timeout_err_out && !err_seen) begin err_seen = 1; err_cyc = cyc; end
        end
    end

    // ---------------- cipher model: returns block XOR all-ones ------------------
    int           cipher_lat = 10;
    int           rcnt       = 0;
    logic [127:0] rblk       = '0;

    initial begin
        bus.cipher_valid_in = 1'b0;
        bus.cipher_block_in = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) rcnt = 0;
            else if (bus.cipher_start_out && cipher_lat > 0) begin
                rcnt = cipher_lat;
                rblk = bus.cipher_block_out ^ {128{1'b1}};
            end
            @(posedge clk_in);
            #1;
            bus.cipher_valid_in = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.cipher_valid_in = 1'b1;
                    bus.cipher_block_in = rblk;
                end
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------------
    task automatic tick(input logic [7:0] s, input bit bz);
        repeat ($urandom_range(2, 4)) @(posedge clk_in);
        #1;
        bus.sample_valid_in = 1'b1;
        bus.sample_in       = s;
        bus.tx_busy_in      = bz;
        @(posedge clk_in);
        #1;
        bus.sample_valid_in = 1'b0;
        bus.tx_busy_in      = 1'b0;
    endtask

    task automatic fill_block(input int base, input bit rnd, input int bpct);
        bus.enable_in = 1'b1;
        for (int i = 0; i < 16; i++)
            tick(rnd ? 8'($urandom) : 8'(base + i), $urandom_range(0, 99) < bpct);
    endtask

    // bpct < 0 stalls exactly the tick that would emit byte 3
    task automatic drain(input int n, input int bpct);
        int k = 0;
        bit stalled = 0;
        bit bz;
        bus.enable_in = 1'b0;
        @(negedge clk_in);
        while (tx_log.size() < n && k < 100) begin
            if (bpct < 0) begin
                bz = (tx_log.size() == 3) && !stalled;
                if (bz) stalled = 1;
            end else begin
                bz = $urandom_range(0, 99) < bpct;
            end
            tick(8'($urandom), bz);
            k++;
            @(negedge clk_in);
        end
        chk("drain_bytes", 128'(tx_log.size()), 128'(n));
    endtask

    function automatic logic [127:0] pack_log();
        logic [127:0] r = '0;
        for (int i = 0; i < 16 && i < tx_log.size(); i++) r[8*i +: 8] = tx_log[i];
        return r;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, {127'd0, bus.cipher_start_out}, 128'd0);
        chk({tag, "_blk"},   bus.cipher_block_out,           128'd0);
        chk({tag, "_txv"},   {127'd0, bus.tx_valid_out},     128'd0);
        chk({tag, "_txb"},   {120'd0, bus.tx_byte_out},      128'd0);
        chk({tag, "_busy"},  {127'd0, bus.busy_out},         128'd0);
        chk({tag, "_drop"},  {120'd0, bus.drop_count_out},   128'd0);
        chk({tag, "_err"},   {127'd0, bus.timeout_err_out},  128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 500000", $time);
        $fatal(1);
    end

    // ---------------- scenarios --------------------------------------------------
    initial begin
        int s0, k;
        bus.enable_in       = 1'b0;
        bus.sample_valid_in = 1'b0;
        bus.sample_in       = 8'd0;
        bus.tx_busy_in      = 1'b0;
        rst_n_in            = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_zero("rst");
        rst_n_in = 1'b1;

        // Nominal: 0x00..0x0F -> bytes 0xFF..0xF0
        cipher_lat = 10;
        tx_log.delete();
        s0 = start_cnt;
        fill_block(0, 0, 0);
        drain(16, 0);
        chk("nom_starts", 128'(start_cnt - s0), 128'd1);
        chk("nom_blk", bus.cipher_block_out, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("nom_tx",  pack_log(),           128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        // Partial block discarded by enable drop
        s0 = start_cnt;
        bus.enable_in = 1'b1;
        for (int i = 0; i < 5; i++) tick(8'($urandom), 0);
        bus.enable_in = 1'b0;
        tick(8'($urandom), 0);
        repeat (20) @(posedge clk_in);
        chk("part_nostart", 128'(start_cnt - s0), 128'd0);
        tx_log.delete();
        fill_block(8'h20, 0, 0);
        drain(16, 0);
        chk("part_starts", 128'(start_cnt - s0), 128'd1);
        chk("part_blk", bus.cipher_block_out, 128'h2F2E2D2C2B2A29282726252423222120);
        chk("part_tx",  pack_log(),           128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);

        // Timeout: cipher never answers
        cipher_lat = 0;
        s0 = start_cnt;
        fill_block(0, 1, 0);
        bus.enable_in = 1'b0;
        k = 0;
        while (!err_seen && k < 400) begin @(negedge clk_in); k++; end
        chk("tmo_flag",  {127'd0, bus.timeout_err_out}, 128'd1);
        chk("tmo_delay", 128'(err_cyc - start_cyc),     128'd100);
        cipher_lat = 10;
        tx_log.delete();
        fill_block(0, 1, 0);
        drain(16, 0);
        chk("tmo_relaunch", 128'(start_cnt - s0), 128'd2);

        // Overrun: 80-cycle cipher latency, 48 continuous samples, random tx busy
        cipher_lat = 80;
        s0 = start_cnt;
        tx_log.delete();
        bus.enable_in = 1'b1;
        for (int i = 0; i < 48; i++) tick(8'($urandom), $urandom_range(0, 99) < 25);
        drain(32, 25);
        chk("ovr_drop",   {120'd0, bus.drop_count_out}, 128'd1);
        chk("ovr_starts", 128'(start_cnt - s0),         128'd2);

        // Busy stall on byte 3
        cipher_lat = 10;
        tx_log.delete();
        fill_block(8'h40, 0, 0);
        drain(16, -1);
        chk("stall_tx", pack_log(), 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);

        // Reset in the middle of a drain
        tx_log.delete();
        fill_block(8'h60, 0, 0);
        drain(8, 0);
        @(posedge clk_in);
        #4;
        rst_n_in = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        tx_log.delete();
        s0 = start_cnt;
        bus.enable_in = 1'b0;
        for (int i = 0; i < 20; i++) tick(8'($urandom), 0);
        @(negedge clk_in);
        chk("post_rst_tx",   128'(tx_log.size()),    128'd0);
        chk("post_rst_busy", {127'd0, bus.busy_out}, 128'd0);
        fill_block(0, 1, 10);
        drain(16, 10);
        chk("post_rst_starts", 128'(start_cnt - s0), 128'd1);

        repeat (5) @(posedge clk_in);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
